// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
//   Bundles the signals between the buart receiver, the uart_rx_fifo receive
//   buffer and the CPU IO read path.
//
//   Signals (direction as seen by the FIFO, i.e. the slave modport):
//     uart_valid   in   buart holds a received byte (level until acknowledged)
//     uart_data    in   buart received byte, stable while uart_valid=1
//     uart_rd      out  one-cycle acknowledge back to buart
//     pop          in   CPU read strobe for the data register
//     rdata        out  head byte of the FIFO, 0 when empty
//     rvalid       out  FIFO not empty
//     count        out  number of bytes held (DEPTH_LOG2+1 bits)
//     overflow     out  sticky: a byte arrived while the FIFO was full
//     overflow_clr in   clears overflow
//
//   The master modport is the environment side (buart + IO page).
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  uart_valid;
   logic [7:0]            uart_data;
   logic                  uart_rd;
   logic                  pop;
   logic [7:0]            rdata;
   logic                  rvalid;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  overflow_clr;

   modport slave (
      input  uart_valid,
      input  uart_data,
      input  pop,
      input  overflow_clr,
      output uart_rd,
      output rdata,
      output rvalid,
      output count,
      output overflow
   );

   modport master (
      output uart_valid,
      output uart_data,
      output pop,
      output overflow_clr,
      input  uart_rd,
      input  rdata,
      input  rvalid,
      input  count,
      input  overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive buffer between the buart receiver and the CPU IO page. Bytes are
//   drained from buart with its valid/rd handshake into a 2**DEPTH_LOG2 deep
//   FIFO; the head byte and status are presented registered (show-ahead) to the
//   IO read mux so firmware can absorb bursts without losing characters.
//
//   Parameters:
//     DEPTH_LOG2      FIFO depth is 2**DEPTH_LOG2 bytes (1..8)
//     DROP_WHEN_FULL  0: leave the byte in buart while full (backpressure)
//                     1: acknowledge and discard the byte while full
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    uart_rx_fifo_if.slave (buart handshake, pop, head data, status)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH_LOG2     = 4,
   parameter bit DROP_WHEN_FULL = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   uart_rx_fifo_if.slave      bus
);

   localparam int              DEPTH    = 2 ** DEPTH_LOG2;
   localparam int              CW       = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACK    = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    rd_q, rd_d;
   logic                    rvalid_q, rvalid_d;
   logic [7:0]              rdata_q, rdata_d;
   logic                    ovf_q, ovf_d;
   logic [7:0]              mem_q [DEPTH];

   logic                    full;
   logic                    wr_en;
   logic                    pop_en;
   logic                    ovf_set;

   assign full = (count_q == FULL_CNT);

   // Intake FSM: capture in IDLE, acknowledge in ACK, then one SETTLE cycle in
   // which uart_valid is ignored because buart only drops it one cycle after rd.
   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      ovf_set = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.uart_valid) begin
               if (!full) begin
                  wr_en   = 1'b1;
                  state_d = S_ACK;
               end else begin
                  ovf_set = 1'b1;
                  // Discard mode still acknowledges so buart can move on.
                  if (DROP_WHEN_FULL) begin
                     state_d = S_ACK;
                  end
               end
            end
         end
         S_ACK:    state_d = S_SETTLE;
         S_SETTLE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      // uart_rd is a flop that is high exactly while the FSM sits in ACK.
      rd_d = (state_d == S_ACK);
   end

   // Pointer, occupancy and registered show-ahead head computation.
   always_comb begin
      // rvalid_q always mirrors count_q != 0, so a pop on empty is dropped here.
      pop_en = bus.pop & rvalid_q;

      wptr_d = wr_en  ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
      rptr_d = pop_en ? rptr_q + DEPTH_LOG2'(1) : rptr_q;

      count_d = count_q;
      unique case ({wr_en, pop_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      rvalid_d = (count_d != '0);

      // The new head is the byte being written this very cycle when the read
      // pointer lands on the write slot; the array only holds it after the edge.
      // (A full FIFO also has rptr==wptr, but then wr_en is low.)
      if (!rvalid_d) begin
         rdata_d = 8'h00;
      end else if (wr_en && (rptr_d == wptr_q)) begin
         rdata_d = bus.uart_data;
      end else begin
         rdata_d = mem_q[rptr_d];
      end

      // Set has priority over a same-cycle clear.
      ovf_d = ovf_set | (ovf_q & ~bus.overflow_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         rd_q     <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= 8'h00;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         rd_q     <= rd_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array carries data only, so it has no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= bus.uart_data;
      end
   end

   assign bus.uart_rd  = rd_q;
   assign bus.rvalid   = rvalid_q;
   assign bus.rdata    = rdata_q;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;

endmodule
